// File: rtl/mul_pkg.sv
// Shared types and constants for the signed sequential multiplier with BCD output.
// Segment vectors are active-low, bit 0 = segment a ... bit 6 = segment g.
package mul_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        CONV = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    function automatic logic [6:0] seg_decode(input logic [3:0] digit);
        logic [6:0] seg;
        case (digit)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/bin_to_bcd_seq.sv
// Sequential double-dabble: load latches the binary value, then one bit is shifted
// in per cycle; done flags the final step and bcd carries that step's result.
module bin_to_bcd_seq #(
    parameter int W      = 9,
    parameter int DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [W-1:0]          bin,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd
);

    localparam int CW = $clog2(W + 1);

    logic [W-1:0]        bin_r;
    logic [4*DIGITS-1:0] bcd_r;
    logic [CW-1:0]       cnt_r;
    logic                run_r;

    logic [4*DIGITS-1:0] adj_s;
    logic [4*DIGITS-1:0] shifted_s;
    logic                done_s;
    logic                unused_msb_s;

    // Add-3 correction on every digit, then shift the next binary bit in.
    always_comb begin
        adj_s = bcd_r;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd_r[4*i +: 4] >= 4'd5) begin
                adj_s[4*i +: 4] = bcd_r[4*i +: 4] + 4'd3;
            end else begin
                adj_s[4*i +: 4] = bcd_r[4*i +: 4];
            end
        end
        shifted_s = {adj_s[4*DIGITS-2:0], bin_r[W-1]};
        done_s    = run_r && (cnt_r == CW'(W - 1));
    end

    // The top digit's MSB can never be set when DIGITS is large enough for W bits.
    assign unused_msb_s = adj_s[4*DIGITS-1];

    // Conversion state: binary shifter, BCD accumulator and step counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bin_r <= '0;
            bcd_r <= '0;
            cnt_r <= '0;
            run_r <= 1'b0;
        end else if (load) begin
            bin_r <= bin;
            bcd_r <= '0;
            cnt_r <= '0;
            run_r <= 1'b1;
        end else if (run_r) begin
            bin_r <= {bin_r[W-2:0], 1'b0};
            bcd_r <= shifted_s;
            cnt_r <= cnt_r + CW'(1);
            run_r <= !done_s;
        end else begin
            bin_r <= bin_r;
            bcd_r <= bcd_r;
            cnt_r <= cnt_r;
            run_r <= run_r;
        end
    end

    assign done = done_s;
    assign bcd  = shifted_s;

endmodule

// File: rtl/signed_seq_mul_bcd.sv
// Signed shift-and-add multiplier with sequential BCD conversion of the magnitude.
// Define MUL_SEVEN_SEG_EN to add the registered active-low DISPLAYS output.
module signed_seq_mul_bcd
    import mul_pkg::*;
#(
    parameter int N      = 5,
    parameter int DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [N-1:0]          A,
    input  logic [N-1:0]          B,
    output logic                  busy,
    output logic                  ready,
    output logic                  neg,
    output logic [2*N-2:0]        mag,
    output logic [4*DIGITS-1:0]   bcd
`ifdef MUL_SEVEN_SEG_EN
    ,
    output logic [7*DIGITS-1:0]   DISPLAYS
`endif
);

    localparam int W  = 2*N - 1;
    localparam int CW = $clog2(N + 1);

    state_t              state_r;
    state_t              state_nxt;
    logic [CW-1:0]       cnt_r;
    logic [W-1:0]        mcand_r;
    logic [N-1:0]        mplier_r;
    logic [W-1:0]        acc_r;
    logic                sign_r;
    logic                busy_r;
    logic                ready_r;
    logic                neg_r;
    logic [W-1:0]        mag_r;
    logic [4*DIGITS-1:0] bcd_r;

    logic [N-1:0]        abs_a_s;
    logic [N-1:0]        abs_b_s;
    logic [W-1:0]        acc_add_s;
    logic                last_mul_s;
    logic                conv_load_s;
    logic                conv_done_s;
    logic [4*DIGITS-1:0] conv_bcd_s;

    // Operand magnitudes and one shift-and-add step; -2^(N-1) maps to 2^(N-1) unsigned.
    always_comb begin
        abs_a_s    = A[N-1] ? (-A) : A;
        abs_b_s    = B[N-1] ? (-B) : B;
        acc_add_s  = mplier_r[0] ? (acc_r + mcand_r) : acc_r;
        last_mul_s = (cnt_r == CW'(N - 1));
    end

    // Next-state logic; the converter is loaded with the final product on the last MUL step.
    always_comb begin
        state_nxt   = state_r;
        conv_load_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_nxt = MUL;
                end else begin
                    state_nxt = IDLE;
                end
            end
            MUL: begin
                if (last_mul_s) begin
                    state_nxt   = CONV;
                    conv_load_s = 1'b1;
                end else begin
                    state_nxt = MUL;
                end
            end
            CONV: begin
                if (conv_done_s) begin
                    state_nxt = DONE;
                end else begin
                    state_nxt = CONV;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    bin_to_bcd_seq #(
        .W      (W),
        .DIGITS (DIGITS)
    ) u_conv (
        .clk  (clk),
        .rst  (rst),
        .load (conv_load_s),
        .bin  (acc_add_s),
        .done (conv_done_s),
        .bcd  (conv_bcd_s)
    );

    // State register, handshake flags, multiply datapath and held results.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r  <= IDLE;
            cnt_r    <= '0;
            mcand_r  <= '0;
            mplier_r <= '0;
            acc_r    <= '0;
            sign_r   <= 1'b0;
            busy_r   <= 1'b0;
            ready_r  <= 1'b0;
            neg_r    <= 1'b0;
            mag_r    <= '0;
            bcd_r    <= '0;
        end else begin
            state_r <= state_nxt;
            busy_r  <= (state_nxt != IDLE);
            ready_r <= (state_nxt == DONE);
            case (state_r)
                IDLE: begin
                    if (start) begin
                        mcand_r  <= {{(N-1){1'b0}}, abs_a_s};
                        mplier_r <= abs_b_s;
                        acc_r    <= '0;
                        sign_r   <= A[N-1] ^ B[N-1];
                        cnt_r    <= '0;
                    end
                end
                MUL: begin
                    acc_r    <= acc_add_s;
                    mcand_r  <= {mcand_r[W-2:0], 1'b0};
                    mplier_r <= {1'b0, mplier_r[N-1:1]};
                    cnt_r    <= cnt_r + CW'(1);
                end
                CONV: begin
                    if (conv_done_s) begin
                        mag_r <= acc_r;
                        bcd_r <= conv_bcd_s;
                        neg_r <= sign_r & (|acc_r);
                    end
                end
                default: begin
                    cnt_r <= cnt_r;
                end
            endcase
        end
    end

    assign busy  = busy_r;
    assign ready = ready_r;
    assign neg   = neg_r;
    assign mag   = mag_r;
    assign bcd   = bcd_r;

`ifdef MUL_SEVEN_SEG_EN
    logic [7*DIGITS-1:0] disp_r;

    // Segment decode registered together with the BCD result.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            disp_r <= {DIGITS{SEG_0}};
        end else if ((state_r == CONV) && conv_done_s) begin
            for (int i = 0; i < DIGITS; i++) begin
                disp_r[7*i +: 7] <= seg_decode(conv_bcd_s[4*i +: 4]);
            end
        end else begin
            disp_r <= disp_r;
        end
    end

    assign DISPLAYS = disp_r;
`endif

endmodule
